// File: rtl/risc_spm_mem_resp.sv
// Wait-state memory responder for the RISC SPM: single-port word array answering each request with a ready pulse.
// Optional write protection of the program region [0..PROG_TOP] is enabled by defining MEM_WP_EN.
module risc_spm_mem_resp #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] PROG_TOP    = 'h7F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              wp_fault
);

`ifdef MEM_WP_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACC,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              wp_fault_q, wp_fault_d;
    logic              wp_block;
    logic              mem_wr;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // A protected write still walks the full FSM so latency is unchanged; only the array update is dropped.
    assign wp_block = WP_EN && we_q && (addr_q <= PROG_TOP);
    assign mem_wr   = (state_q == S_ACC) && we_q && !wp_block;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    cnt_d   = WAIT_LD;
                    state_d = (WAIT_LD == 4'd0) ? S_ACC : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_ACC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACC: begin
                if (!we_q) begin
                    rdata_d = mem[addr_q];
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d    = (state_d == S_RESP);
        busy_d     = (state_d != S_IDLE);
        wp_fault_d = (state_q == S_ACC) && wp_block;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            wp_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            wp_fault_q <= wp_fault_d;
        end
    end

    // Request capture registers are only consumed after a load, so they need no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
    end

    // Array contents deliberately survive reset; the ACC state is forced off by reset, which blocks the commit.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign wp_fault = wp_fault_q;

endmodule

// File: tb/tb_risc_spm_mem_resp.sv
// Scoreboard bench for risc_spm_mem_resp: one instance with zero wait states, one with a single wait state.
module tb_risc_spm_mem_resp;

`ifdef MEM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    typedef struct {
        int         dut;
        logic [7:0] rd;
        logic       wp;
        int         cyc;
        logic       rd_ne;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req   [2];
    logic       we    [2];
    logic [7:0] addr  [2];
    logic [7:0] wdata [2];
    logic [7:0] rdata [2];
    logic       ready [2];
    logic       busy  [2];
    logic       wpf   [2];

    exp_t       sb[$];
    exp_t       mon_e;
    int         errs   = 0;
    int         checks = 0;
    int         cyc    = 0;
    logic [7:0] mdl     [2][256];
    logic [7:0] last_rd [2];

    risc_spm_mem_resp #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(0), .PROG_TOP(8'h7F)) u_dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]), .wp_fault(wpf[0])
    );

    risc_spm_mem_resp #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(1), .PROG_TOP(8'h7F)) u_dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]), .wp_fault(wpf[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ready[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("ready_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_dut", i, mon_e.dut);
                    chk("latency", cyc, mon_e.cyc);
                    chk("wp_fault", {31'd0, wpf[i]}, {31'd0, mon_e.wp});
                    if (mon_e.rd_ne) chk("rdata_not_ff", {31'd0, rdata[i] == 8'hFF}, 32'd0);
                    else             chk("rdata", {24'd0, rdata[i]}, {24'd0, mon_e.rd});
                end
            end else if (wpf[i] !== 1'b0) begin
                chk("wp_fault_alone", {31'd0, wpf[i]}, 32'd0);
            end
        end
    end

    task automatic txn(input int i, input bit w, input logic [7:0] a, input logic [7:0] d,
                       input bit rd_ne);
        int   acc;
        exp_t e;
        bit   blk;
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        @(posedge clk); #1;
        acc = cyc;
        req[i] = 1'b0; we[i] = ~w; addr[i] = ~a; wdata[i] = ~d;
        blk     = WP && w && (a <= 8'h7F);
        e.dut   = i;
        e.cyc   = acc + wc(i) + 1;
        e.wp    = blk;
        e.rd_ne = rd_ne;
        if (w) begin
            e.rd = last_rd[i];
            if (!blk) mdl[i][a] = d;
        end else begin
            e.rd = mdl[i][a];
            last_rd[i] = e.rd;
        end
        sb.push_back(e);
        for (int k = 0; k < wc(i) + 2; k++) begin
            @(negedge clk);
            chk("busy", {31'd0, busy[i]}, 32'd1);
        end
        @(negedge clk);
        chk("busy_end", {31'd0, busy[i]}, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int         acc;
        exp_t       e;
        logic [7:0] ha;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 8'h00; wdata[i] = 8'h00; last_rd[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", {31'd0, ready[i]}, 32'd0);
            chk("rst_busy", {31'd0, busy[i]}, 32'd0);
            chk("rst_rdata", {24'd0, rdata[i]}, 32'd0);
            chk("rst_wp_fault", {31'd0, wpf[i]}, 32'd0);
        end
        rst = 1'b0;

        // basic write/read with one wait state
        txn(1, 1'b1, 8'h90, 8'hA5, 1'b0);
        txn(1, 1'b0, 8'h90, 8'h00, 1'b0);

        // zero wait states
        txn(0, 1'b1, 8'h00, 8'h51, 1'b0);
        txn(0, 1'b0, 8'h00, 8'h00, 1'b0);

        // req held high over three reads, inputs disturbed mid-transaction
        txn(1, 1'b1, 8'h10, 8'hC1, 1'b0);
        txn(1, 1'b1, 8'h11, 8'hC2, 1'b0);
        txn(1, 1'b1, 8'h12, 8'hC3, 1'b0);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h10;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            acc = cyc;
            ha  = 8'(8'h10 + t);
            e.dut = 1; e.rd = mdl[1][ha]; e.wp = 1'b0; e.cyc = acc + 2; e.rd_ne = 1'b0;
            last_rd[1] = e.rd;
            sb.push_back(e);
            addr[1] = 8'h55; we[1] = 1'b1; wdata[1] = 8'hEE;
            if (t == 2) req[1] = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
            end
            if (t < 2) begin
                we[1]   = 1'b0;
                addr[1] = 8'(8'h11 + t);
            end
        end
        we[1] = 1'b0;
        repeat (2) @(negedge clk);

        // reset during the wait state of a write
        txn(1, 1'b1, 8'h20, 8'h00, 1'b0);
        txn(1, 1'b1, 8'h21, 8'h77, 1'b0);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h20; wdata[1] = 8'h3C;
        @(posedge clk); #1;
        req[1] = 1'b0;
        chk("busy_in_wait", {31'd0, busy[1]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_ready", {31'd0, ready[1]}, 32'd0);
        chk("arst_busy", {31'd0, busy[1]}, 32'd0);
        chk("arst_rdata", {24'd0, rdata[1]}, 32'd0);
        chk("arst_wp_fault", {31'd0, wpf[1]}, 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_ready", {31'd0, ready[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        txn(1, 1'b0, 8'h20, 8'h00, 1'b0);
        txn(1, 1'b0, 8'h21, 8'h00, 1'b0);

        // program-region write protection (behaviour depends on MEM_WP_EN)
        txn(0, 1'b1, 8'h80, 8'hFF, 1'b0);
        txn(0, 1'b0, 8'h80, 8'h00, 1'b0);
        txn(0, 1'b1, 8'h05, 8'hFF, 1'b0);
        txn(0, 1'b0, 8'h05, 8'h00, WP);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
